// File: rtl/milano_pkg.sv
// Shared types for the milano memory-port arbiter: owner tags, FSM states
// and the muxed memory command.
package milano_pkg;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } arb_owner_e;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_cmd_t;

    localparam logic [3:0] INSTR_BE = 4'hF;

    // Fetches are always full-word reads.
    function automatic mem_cmd_t instr_cmd(input logic [31:0] addr);
        mem_cmd_t cmd;
        cmd.addr  = addr;
        cmd.we    = 1'b0;
        cmd.be    = INSTR_BE;
        cmd.wdata = '0;
        return cmd;
    endfunction

endpackage

// File: rtl/milano_owner_fifo.sv
// In-order record of which port owns each outstanding memory transaction.
// One bit per entry; pointers wrap at DEPTH so any depth >= 1 works.
module milano_owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  logic push_data_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic             slot_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = slot_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= 1'b0;
            end
        end else if (do_push) begin
            slot_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/milano_mem_arbiter.sv
// Two-port (fetch / LSU) arbiter onto one req/gnt/rvalid memory port, with
// in-order response routing and bounded fetch starvation.
module milano_mem_arbiter
    import milano_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        err_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e       state_q, state_d;
    arb_owner_e       lock_q, lock_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             err_q;

    arb_owner_e sel_owner;
    logic       req_valid;
    logic       grant;
    logic       instr_starved;
    mem_cmd_t   data_cmd;
    mem_cmd_t   mem_cmd;

    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;
    arb_owner_e head_owner;

    assign instr_starved = instr_req_i && (starve_q == STARVE_MAX);

    // Next state and owner selection; a pending address phase that missed
    // mem_gnt_i is locked so its attributes stay stable until accepted.
    always_comb begin
        state_d   = state_q;
        lock_d    = lock_q;
        sel_owner = OWNER_DATA;
        req_valid = 1'b0;
        if (state_q == ARB_IDLE) begin
            if ((instr_req_i || data_req_i) && !fifo_full) begin
                req_valid = 1'b1;
                if (data_req_i && !instr_starved) begin
                    sel_owner = OWNER_DATA;
                end else begin
                    sel_owner = OWNER_INSTR;
                end
                if (!mem_gnt_i) begin
                    state_d = ARB_LOCKED;
                    lock_d  = sel_owner;
                end
            end
        end else begin
            req_valid = 1'b1;
            sel_owner = lock_q;
            if (mem_gnt_i) begin
                state_d = ARB_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            lock_q  <= OWNER_INSTR;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

    // Outputs are held at zero while reset is asserted.
    assign mem_req_o   = rst_ni && req_valid;
    assign grant       = mem_req_o && mem_gnt_i;
    assign instr_gnt_o = grant && (sel_owner == OWNER_INSTR);
    assign data_gnt_o  = grant && (sel_owner == OWNER_DATA);

    assign data_cmd.addr  = data_addr_i;
    assign data_cmd.we    = data_we_i;
    assign data_cmd.be    = data_be_i;
    assign data_cmd.wdata = data_wdata_i;

    always_comb begin
        mem_cmd = '0;
        if (mem_req_o) begin
            mem_cmd = (sel_owner == OWNER_DATA) ? data_cmd : instr_cmd(instr_addr_i);
        end
    end

    assign mem_addr_o  = mem_cmd.addr;
    assign mem_we_o    = mem_cmd.we;
    assign mem_be_o    = mem_cmd.be;
    assign mem_wdata_o = mem_cmd.wdata;

    assign fifo_push = grant;
    assign fifo_pop  = mem_rvalid_i && !fifo_empty;

    milano_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (fifo_push),
        .push_data_i (sel_owner == OWNER_DATA),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    assign head_owner     = arb_owner_e'(fifo_head);
    assign instr_rvalid_o = rst_ni && fifo_pop && (head_owner == OWNER_INSTR);
    assign data_rvalid_o  = rst_ni && fifo_pop && (head_owner == OWNER_DATA);
    assign instr_rdata_o  = rst_ni ? mem_rdata_i : '0;
    assign data_rdata_o   = rst_ni ? mem_rdata_i : '0;

    always_comb begin
        starve_d = starve_q;
        if (!instr_req_i || instr_gnt_o) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            starve_q <= starve_d;
            // A response with nothing outstanding means the memory side is broken.
            if (mem_rvalid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;

    a_locked_req_held: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (state_q == ARB_LOCKED) |-> ((lock_q == OWNER_DATA) ? data_req_i : instr_req_i)
    );

    a_grant_needs_mem_gnt: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (instr_gnt_o || data_gnt_o) |-> mem_gnt_i
    );

    a_no_push_when_full: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        fifo_full |-> !fifo_push
    );

endmodule

// File: tb/tb_milano_mem_arbiter.sv
// Self-checking bench for milano_mem_arbiter: table vectors, directed
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_milano_mem_arbiter;

    localparam int MAX_OUT  = 2;
    localparam int LIMIT    = 4;
    localparam int RAND_CYC = 400;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = '0;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i = 1'b0;
    logic [31:0] data_addr_i = '0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        err_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    milano_mem_arbiter #(
        .MAX_OUTSTANDING (MAX_OUT),
        .STARVE_LIMIT    (LIMIT)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_addr_i    (data_addr_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_addr_o     (mem_addr_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .err_o          (err_o)
    );

    typedef struct packed {
        logic        ireq;
        logic        dreq;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_ig;
        logic        e_dg;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    function automatic logic [159:0] all_outs();
        return {instr_gnt_o, instr_rvalid_o, instr_rdata_o, data_gnt_o, data_rvalid_o,
                data_rdata_o, mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, err_o};
    endfunction

    // Randomized-phase model state
    int          q_own [$];
    int          lock_o;
    int          starve;
    int          cand;
    logic        ipend, dpend, issue;
    logic        e_ig, e_dg, e_irv, e_drv;
    logic [31:0] e_addr, e_wdata;
    logic        e_we;
    logic [3:0]  e_be;
    int          cyc;
    logic        got;

    initial begin
        vecs[0] = '{ireq:1'b1, dreq:1'b0, iaddr:32'h80, daddr:32'h0, we:1'b0, be:4'h0,
                    wdata:32'h0, rdata:32'h13, e_req:1'b1, e_ig:1'b1, e_dg:1'b0,
                    e_addr:32'h80, e_we:1'b0, e_be:4'hF, e_wdata:32'h0};
        vecs[1] = '{ireq:1'b0, dreq:1'b1, iaddr:32'h44, daddr:32'h1000, we:1'b0, be:4'h3,
                    wdata:32'h0, rdata:32'h2222_0001, e_req:1'b1, e_ig:1'b0, e_dg:1'b1,
                    e_addr:32'h1000, e_we:1'b0, e_be:4'h3, e_wdata:32'h0};
        vecs[2] = '{ireq:1'b0, dreq:1'b1, iaddr:32'h48, daddr:32'h2004, we:1'b1, be:4'hF,
                    wdata:32'hCAFE_F00D, rdata:32'h0, e_req:1'b1, e_ig:1'b0, e_dg:1'b1,
                    e_addr:32'h2004, e_we:1'b1, e_be:4'hF, e_wdata:32'hCAFE_F00D};
        vecs[3] = '{ireq:1'b0, dreq:1'b0, iaddr:32'h50, daddr:32'h5000, we:1'b1, be:4'hF,
                    wdata:32'h1, rdata:32'h0, e_req:1'b0, e_ig:1'b0, e_dg:1'b0,
                    e_addr:32'h0, e_we:1'b0, e_be:4'h0, e_wdata:32'h0};
        vecs[4] = '{ireq:1'b1, dreq:1'b0, iaddr:32'hFFFF_FFFC, daddr:32'h0, we:1'b1, be:4'h1,
                    wdata:32'h9, rdata:32'hFFFF_FFFF, e_req:1'b1, e_ig:1'b1, e_dg:1'b0,
                    e_addr:32'hFFFF_FFFC, e_we:1'b0, e_be:4'hF, e_wdata:32'h0};
        vecs[5] = '{ireq:1'b0, dreq:1'b1, iaddr:32'h0, daddr:32'h3008, we:1'b1, be:4'h8,
                    wdata:32'h1234_5678, rdata:32'h0, e_req:1'b1, e_ig:1'b0, e_dg:1'b1,
                    e_addr:32'h3008, e_we:1'b1, e_be:4'h8, e_wdata:32'h1234_5678};

        // Reset: outputs zero even with requests and grant present
        instr_req_i = 1'b1;
        data_req_i  = 1'b1;
        mem_gnt_i   = 1'b1;
        smp();
        chk("reset_outs", all_outs(), '0);
        step();
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        rst_ni      = 1'b1;
        smp();
        chk("idle_outs", all_outs(), '0);
        step();

        // Table vectors: one address phase with gnt high, response next cycle
        for (int i = 0; i < 6; i++) begin
            instr_req_i  = vecs[i].ireq;
            instr_addr_i = vecs[i].iaddr;
            data_req_i   = vecs[i].dreq;
            data_addr_i  = vecs[i].daddr;
            data_we_i    = vecs[i].we;
            data_be_i    = vecs[i].be;
            data_wdata_i = vecs[i].wdata;
            mem_gnt_i    = 1'b1;
            mem_rvalid_i = 1'b0;
            smp();
            chk($sformatf("vec%0d_ctrl", i), {mem_req_o, instr_gnt_o, data_gnt_o},
                {vecs[i].e_req, vecs[i].e_ig, vecs[i].e_dg});
            if (vecs[i].e_req) begin
                chk($sformatf("vec%0d_attr", i), {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o},
                    {vecs[i].e_addr, vecs[i].e_we, vecs[i].e_be, vecs[i].e_wdata});
            end
            step();
            instr_req_i  = 1'b0;
            data_req_i   = 1'b0;
            mem_rvalid_i = vecs[i].e_ig | vecs[i].e_dg;
            mem_rdata_i  = vecs[i].rdata;
            smp();
            chk($sformatf("vec%0d_rvalid", i), {instr_rvalid_o, data_rvalid_o},
                {vecs[i].e_ig, vecs[i].e_dg});
            if (vecs[i].e_ig) chk($sformatf("vec%0d_irdata", i), instr_rdata_o, vecs[i].rdata);
            if (vecs[i].e_dg) chk($sformatf("vec%0d_drdata", i), data_rdata_o, vecs[i].rdata);
            step();
            mem_rvalid_i = 1'b0;
            $display("vec %0d: ireq=%0b dreq=%0b mem_addr=%h", i, vecs[i].ireq, vecs[i].dreq, vecs[i].e_addr);
        end

        // Both request together: data first, then instr; responses in that order
        instr_req_i = 1'b1; instr_addr_i = 32'h100;
        data_req_i = 1'b1; data_addr_i = 32'h200; data_we_i = 1'b0; data_be_i = 4'hF; data_wdata_i = '0;
        mem_gnt_i = 1'b1;
        smp();
        chk("both_c1", {data_gnt_o, instr_gnt_o, mem_addr_o}, {1'b1, 1'b0, 32'h200});
        step();
        data_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA1;
        smp();
        chk("both_c2", {instr_gnt_o, mem_addr_o, data_rvalid_o, instr_rvalid_o, data_rdata_o},
            {1'b1, 32'h100, 1'b1, 1'b0, 32'hA1});
        step();
        instr_req_i = 1'b0; mem_rdata_i = 32'hB2;
        smp();
        chk("both_c3", {instr_rvalid_o, data_rvalid_o, instr_rdata_o}, {1'b1, 1'b0, 32'hB2});
        step();
        mem_rvalid_i = 1'b0;
        $display("seq both: data then instr");

        // Starvation: data held continuously; instr must win at cycle LIMIT+1
        instr_req_i = 1'b1; instr_addr_i = 32'h300;
        data_req_i = 1'b1; data_addr_i = 32'h400;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 10) begin
            cyc++;
            smp();
            got = instr_gnt_o;
            step();
            if (!got) mem_rvalid_i = 1'b1;
        end
        chk("starve_latency", cyc, LIMIT + 1);
        instr_req_i = 1'b0; data_req_i = 1'b0; mem_rvalid_i = 1'b1;
        smp();
        chk("starve_rsp", {instr_rvalid_o, data_rvalid_o}, 2'b10);
        step();
        mem_rvalid_i = 1'b0;
        $display("seq starve: instr granted at cycle %0d", cyc);

        // Locked data phase with gnt low for 3 cycles, instr arrives mid-wait
        data_req_i = 1'b1; data_addr_i = 32'h500; data_we_i = 1'b1; data_be_i = 4'hC; data_wdata_i = 32'h77;
        mem_gnt_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            smp();
            chk($sformatf("lock_wait%0d", k), {mem_req_o, data_gnt_o, instr_gnt_o, mem_addr_o, mem_be_o},
                {1'b1, 1'b0, 1'b0, 32'h500, 4'hC});
            step();
            if (k == 1) begin instr_req_i = 1'b1; instr_addr_i = 32'h600; end
            if (k == 3) mem_gnt_i = 1'b1;
        end
        smp();
        chk("lock_grant", {data_gnt_o, instr_gnt_o, mem_addr_o}, {1'b1, 1'b0, 32'h500});
        step();
        data_req_i = 1'b0;
        smp();
        chk("lock_after", {instr_gnt_o, mem_addr_o, mem_we_o, mem_be_o}, {1'b1, 32'h600, 1'b0, 4'hF});
        step();
        instr_req_i = 1'b0; mem_rvalid_i = 1'b1;
        smp();
        chk("lock_rsp1", {data_rvalid_o, instr_rvalid_o}, 2'b10);
        step();
        smp();
        chk("lock_rsp2", {data_rvalid_o, instr_rvalid_o}, 2'b01);
        step();
        mem_rvalid_i = 1'b0;
        $display("seq lock: data held through 3 stalled cycles");

        // Outstanding limit: two grants fill the FIFO, request blocked until a pop
        instr_req_i = 1'b1; instr_addr_i = 32'h700; mem_gnt_i = 1'b1;
        smp();
        chk("full_g1", instr_gnt_o, 1'b1);
        step();
        instr_addr_i = 32'h704;
        smp();
        chk("full_g2", instr_gnt_o, 1'b1);
        step();
        instr_addr_i = 32'h708;
        smp();
        chk("full_block", {mem_req_o, instr_gnt_o}, 2'b00);
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11;
        smp();
        chk("full_pop_same", {mem_req_o, instr_gnt_o, instr_rvalid_o}, 3'b001);
        step();
        mem_rvalid_i = 1'b0;
        smp();
        chk("full_resume", {mem_req_o, instr_gnt_o, mem_addr_o}, {1'b1, 1'b1, 32'h708});
        step();
        instr_req_i = 1'b0; mem_rvalid_i = 1'b1;
        smp();
        chk("full_drain1", instr_rvalid_o, 1'b1);
        step();
        smp();
        chk("full_drain2", instr_rvalid_o, 1'b1);
        step();
        mem_rvalid_i = 1'b0;
        $display("seq full: blocked at %0d outstanding", MAX_OUT);

        // Spurious rvalid sets sticky err_o; reset mid-lock clears everything
        mem_rvalid_i = 1'b1;
        smp();
        chk("err_spur_rv", {instr_rvalid_o, data_rvalid_o, err_o}, 3'b000);
        step();
        mem_rvalid_i = 1'b0;
        smp();
        chk("err_set", err_o, 1'b1);
        step();
        step();
        smp();
        chk("err_held", err_o, 1'b1);
        step();
        data_req_i = 1'b1; data_addr_i = 32'h900; mem_gnt_i = 1'b0;
        smp();
        chk("rst_lock1", {mem_req_o, mem_addr_o}, {1'b1, 32'h900});
        step();
        smp();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_async_outs", all_outs(), '0);
        step();
        smp();
        chk("rst_hold_outs", all_outs(), '0);
        step();
        data_req_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'hA00;
        rst_ni = 1'b1;
        smp();
        chk("rst_idle", {mem_req_o, instr_gnt_o, mem_addr_o, err_o}, {1'b1, 1'b0, 32'hA00, 1'b0});
        step();
        mem_gnt_i = 1'b1;
        smp();
        chk("rst_gnt", instr_gnt_o, 1'b1);
        step();
        instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        smp();
        chk("rst_rsp", instr_rvalid_o, 1'b1);
        step();
        mem_rvalid_i = 1'b0;
        $display("seq err/reset done");

        // Randomized traffic against the owner-queue model
        lock_o = -1; starve = 0; ipend = 1'b0; dpend = 1'b0;
        for (int c = 0; c < RAND_CYC + 80; c++) begin
            issue = (c < RAND_CYC);
            if (!ipend && issue && $urandom_range(0, 1) == 1) begin
                ipend = 1'b1;
                instr_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (!dpend && issue && $urandom_range(0, 2) != 0) begin
                dpend = 1'b1;
                data_addr_i  = $urandom;
                data_we_i    = 1'($urandom);
                data_be_i    = 4'($urandom);
                data_wdata_i = $urandom;
            end
            instr_req_i  = ipend;
            data_req_i   = dpend;
            mem_gnt_i    = 1'($urandom_range(0, 1));
            mem_rvalid_i = (q_own.size() > 0) && ($urandom_range(0, 2) != 0);
            mem_rdata_i  = $urandom;

            cand = -1;
            if (lock_o >= 0) cand = lock_o;
            else if (q_own.size() < MAX_OUT && (ipend || dpend))
                cand = (dpend && !(ipend && starve == LIMIT)) ? 1 : 0;
            e_ig  = (cand == 0) && mem_gnt_i;
            e_dg  = (cand == 1) && mem_gnt_i;
            e_irv = mem_rvalid_i && (q_own[0] == 0);
            e_drv = mem_rvalid_i && (q_own[0] == 1);
            if (cand == 1) begin
                e_addr = data_addr_i; e_we = data_we_i; e_be = data_be_i; e_wdata = data_wdata_i;
            end else begin
                e_addr = instr_addr_i; e_we = 1'b0; e_be = 4'hF; e_wdata = '0;
            end

            smp();
            chk($sformatf("rand%0d_ctrl", c),
                {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, err_o},
                {cand >= 0, e_ig, e_dg, e_irv, e_drv, 1'b0});
            if (cand >= 0)
                chk($sformatf("rand%0d_attr", c), {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o},
                    {e_addr, e_we, e_be, e_wdata});
            if (mem_rvalid_i)
                chk($sformatf("rand%0d_rdata", c), {instr_rdata_o, data_rdata_o}, {mem_rdata_i, mem_rdata_i});

            if (mem_rvalid_i) begin
                $display("rand txn: rsp to %s rdata=%h", (q_own[0] == 1) ? "data" : "instr", mem_rdata_i);
                void'(q_own.pop_front());
            end
            if (e_ig || e_dg) q_own.push_back(cand);
            lock_o = (cand >= 0 && !mem_gnt_i) ? cand : -1;
            starve = (!ipend || e_ig) ? 0 : ((starve < LIMIT) ? starve + 1 : LIMIT);
            if (e_ig) ipend = 1'b0;
            if (e_dg) dpend = 1'b0;
            step();
        end
        chk("rand_drained", {q_own.size() == 0, ipend, dpend}, 3'b100);
        instr_req_i = 1'b0; data_req_i = 1'b0; mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
